data_memory_unaligned: RTL and testbench
========================================

// Module: data_memory_unaligned
// PURPOSE
//  Next-generation data memory for the single-cycle/multicycle datapath: clocked, handshaked byte-addressed RAM.
//  Supports byte/half/word loads and stores, sign/zero extension and unaligned accesses that cross a word.
//  Crossing accesses are split into two word accesses by an internal FSM.
//  Sits between the ALU address result and the writeback mux; little-endian byte lanes.
// PARAMETERS
//  WORDS   1024  number of 32-bit words (byte address space = 4*WORDS)
//  ADDR_W  32    width of req_addr in bits
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       block can accept; transfer when req_valid & req_ready
//  req_write   in   1       1 = store, 0 = load
//  req_size    in   2       00 byte, 01 half, 10 word, 11 reserved (error)
//  req_unsigned in  1       loads: 1 zero-extend, 0 sign-extend
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data; low bytes used for byte/half
//  rsp_valid   out  1       response present; held until rsp_ready
//  rsp_ready   in   1       consumer accepts response
//  rsp_rdata   out  32      load data, extended; 0 for stores and errors
//  rsp_err     out  1       out of range, reserved size, or trapped misalignment
// BEHAVIOUR
//  Reset: req_ready=0 during reset, 1 on first cycle after; rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE.
//  Memory contents are zero at time 0 and are NOT cleared by reset.
//  FSM: IDLE -> ACC0 on accepted request.
//   ACC0 -> ACC1 if the access crosses a word, else -> RESP.
//   ACC1 -> RESP. RESP -> IDLE when rsp_ready=1.
//  req_ready=1 only in IDLE; no request is accepted in any other state.
//  Latency: non-crossing rsp_valid 2 cycles after acceptance; crossing 3 cycles.
//  Lanes: byte k of word (addr>>2) holds addr%4==k; bytes beyond word lane 3 go to lanes 0.. of word+1.
//  Stores: per-byte write enables only; untouched bytes are preserved.
//  Crossing stores write word0 in ACC0 and word1 in ACC1.
//  Range check: if any touched byte >= 4*WORDS, or size==11 -> rsp_err=1, no write, rsp_rdata=0.
//   Checked at acceptance, so a split never partially errors.
//  Reset mid-operation: FSM to IDLE, pending response discarded.
//   A crossing store reset between ACC0 and ACC1 leaves word0 updated, word1 old (accepted, documented).
//  A load immediately following a store to the same bytes returns the new data.
//  Address wrap-around is not performed; top-of-memory crossing is an error.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: any addr not a multiple of size bytes -> rsp_err=1, no write, rdata 0.
//   No ACC1 state; response 2 cycles after acceptance.
//  MISALIGN_TRAP_EN undefined: misaligned accesses are serviced; word-crossing accesses are split as above.
// STRUCTURE
//  Package data_memory_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum.
//   Also holds function byte_en(size, addr[1:0]) -> 8-bit two-word lane mask, and function extend(size, unsigned, bytes).
//  Sub-module dmem_byte_lane_ram: WORDS x 32 array, 4 byte write enables, synchronous read.
//  Top holds FSM, address split, lane rotation, response register.
// TESTING
//  1. Reset, store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_rdata=0xDEADBEEF, err=0, latency 2.
//  2. Store byte 0x80 @0x11; load byte signed -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0xDEAD80EF.
//  3. Store word 0x11223344 @0x1E, load word @0x1E -> 0x11223344, latency 3.
//     Word @0x1C upper half = 0x3344; word @0x20 lower half = 0x1122.
//     With MISALIGN_TRAP_EN: err=1, memory unchanged.
//  4. Load half @0xFFF (WORDS=1024) -> err=1, rdata=0. Store size=11 @0x0 -> err=1, memory unchanged.
//  5. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0; release -> IDLE next cycle.
//  6. Assert rst_n=0 in ACC1 of crossing store -> outputs reset async.
//     Word0 updated, word1 unchanged; next request accepted.

Source files
------------

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - size encodings, FSM states and lane helpers for data_memory_unaligned
package data_memory_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Two-word lane mask: bits [3:0] are lanes of word0, bits [7:4] lanes of word0+1.
    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            SZ_WORD: base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    // Sign/zero extension of the little-endian bytes already shifted down to bit 0.
    function automatic logic [31:0] extend(input logic [1:0] size, input logic uns_flag,
                                           input logic [31:0] bytes);
        case (size)
            SZ_BYTE: return uns_flag ? {24'h0, bytes[7:0]} : {{24{bytes[7]}}, bytes[7:0]};
            SZ_HALF: return uns_flag ? {16'h0, bytes[15:0]} : {{16{bytes[15]}}, bytes[15:0]};
            SZ_WORD: return bytes;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_lane_ram.sv
// rtl/dmem_byte_lane_ram.sv - WORDS x 32 RAM with per-byte write enables and registered read
module dmem_byte_lane_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:WORDS-1];
    logic [31:0] r_rdata;

    // Byte-lane writes and a registered read; read data holds while i_en is low.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int k = 0; k < 4; k++) begin
                if (i_we[k]) begin
                    r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_unaligned.sv
// rtl/data_memory_unaligned.sv - handshaked byte-addressed data memory with unaligned access splitting (option: MISALIGN_TRAP_EN)
module data_memory_unaligned
    import data_memory_pkg::*;
#(
    parameter int WORDS  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int              AW        = $clog2(WORDS);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4 * WORDS);

    state_t r_state;
    state_t w_state_next;

    logic          r_live;
    logic          r_write;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [1:0]    r_off;
    logic [AW-1:0] r_widx;
    logic [63:0]   r_wdata_rot;
    logic [7:0]    r_be;
    logic          r_err;
    logic          r_cross;
    logic [31:0]   r_word0;

    logic          w_accept;
    logic [1:0]    w_len_m1;
    logic [ADDR_W:0] w_last;
    logic          w_req_err;
    logic [7:0]    w_be;
    logic          w_cross;

    logic          w_ram_en;
    logic [3:0]    w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_q;
    logic [63:0]   w_pair;
    logic [31:0]   w_aligned;
    logic [31:0]   w_ext;

    assign w_accept = req_valid && req_ready;
    assign w_be     = byte_en(req_size, req_addr[1:0]);

    // Offset of the last touched byte relative to req_addr.
    always_comb begin
        w_len_m1 = 2'd0;
        case (req_size)
            SZ_HALF: w_len_m1 = 2'd1;
            SZ_WORD: w_len_m1 = 2'd3;
            default: w_len_m1 = 2'd0;
        endcase
    end

    // Extra bit keeps addr+3 from wrapping at the top of the address space.
    assign w_last = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, w_len_m1};

`ifdef MISALIGN_TRAP_EN
    assign w_req_err = (req_size == SZ_RSVD) || (w_last >= MEM_BYTES) ||
                       ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_cross   = 1'b0;
`else
    assign w_req_err = (req_size == SZ_RSVD) || (w_last >= MEM_BYTES);
    assign w_cross   = |w_be[7:4];
`endif

    // Ready only comes up on the first clock after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: errored requests still take the ACC0 slot so latency is uniform.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_ACC0;
            ST_ACC0: w_state_next = r_cross ? ST_ACC1 : ST_RESP;
            ST_ACC1: w_state_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Capture the request, pre-rotating store data onto the two-word lane window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_size      <= SZ_BYTE;
            r_uns       <= 1'b0;
            r_off       <= 2'd0;
            r_widx      <= '0;
            r_wdata_rot <= 64'h0;
            r_be        <= 8'h0;
            r_err       <= 1'b0;
            r_cross     <= 1'b0;
        end else if (w_accept) begin
            r_write     <= req_write;
            r_size      <= req_size;
            r_uns       <= req_unsigned;
            r_off       <= req_addr[1:0];
            r_widx      <= req_addr[AW+1:2];
            r_wdata_rot <= 64'({32'h0, req_wdata} << {req_addr[1:0], 3'b000});
            r_be        <= w_be;
            r_err       <= w_req_err;
            r_cross     <= w_cross && !w_req_err;
        end
    end

    // Word0 read data is parked here while word1 is fetched in ACC1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word0 <= 32'h0;
        end else if (r_state == ST_ACC1) begin
            r_word0 <= w_q;
        end
    end

    // RAM port: word0 in ACC0, word0+1 in ACC1; no write enables for errored requests.
    always_comb begin
        w_ram_en    = (r_state == ST_ACC0) || (r_state == ST_ACC1);
        w_ram_addr  = (r_state == ST_ACC1) ? r_widx + AW'(1) : r_widx;
        w_ram_wdata = (r_state == ST_ACC1) ? r_wdata_rot[63:32] : r_wdata_rot[31:0];
        w_ram_we    = 4'h0;
        if (r_write && !r_err) begin
            if (r_state == ST_ACC0) w_ram_we = r_be[3:0];
            if (r_state == ST_ACC1) w_ram_we = r_be[7:4];
        end
    end

    dmem_byte_lane_ram #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_q)
    );

    // RAM output holds through RESP, so the response stays stable while stalled.
    assign w_pair    = r_cross ? {w_q, r_word0} : {32'h0, w_q};
    assign w_aligned = 32'(w_pair >> {r_off, 3'b000});
    assign w_ext     = extend(r_size, r_uns, w_aligned);

    assign req_ready = (r_state == ST_IDLE) && r_live;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && !r_err && !r_write) ? w_ext : 32'h0;

endmodule

// File: tb/tb_data_memory_unaligned.sv
// tb/tb_data_memory_unaligned.sv - scoreboard bench for data_memory_unaligned
module tb_data_memory_unaligned;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [32:0] sb [$];
    logic [7:0]  model [0:4095];

    data_memory_unaligned #(.WORDS(1024), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        longint last;
        if (sz == 2'b11) return 1'b1;
        last = longint'(a) + longint'(nbytes(sz)) - 1;
        if (last >= 4096) return 1'b1;
`ifdef MISALIGN_TRAP_EN
        if ((a % nbytes(sz)) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = model[int'(a) + i];
        if (sz == 2'b00 && !uns) v = {{24{v[7]}}, v[7:0]};
        if (sz == 2'b01 && !uns) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic int m_lat(input logic [1:0] sz, input logic [31:0] a);
        if (m_err(sz, a)) return 2;
        return ((int'(a[1:0]) + nbytes(sz) - 1) > 3) ? 3 : 2;
    endfunction

    // One request/response; expectation is queued at drive time and popped on rsp_valid.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_e,
                          input int exp_lat, input int hold, input string tag);
        int n;
        int lat;
        logic [32:0] item;
        logic [31:0] d0;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        rsp_ready    = (hold == 0);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        sb.push_back({exp_e, exp_d});
        if (w && !m_err(sz, a)) begin
            for (int i = 0; i < nbytes(sz); i++) model[int'(a) + i] = wd[8*i +: 8];
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (rsp_valid === 1'b1 && sb.size() > 0) begin
            item = sb.pop_front();
            check({tag, " rdata"}, rsp_rdata, item[31:0]);
            check({tag, " err"}, {31'b0, rsp_err}, {31'b0, item[32]});
        end
        if (hold > 0) begin
            d0 = rsp_rdata;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, " hold valid"}, {31'b0, rsp_valid}, 32'd1);
                check({tag, " hold rdata"}, rsp_rdata, d0);
                check({tag, " hold ready"}, {31'b0, req_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            check({tag, " release valid"}, {31'b0, rsp_valid}, 32'd0);
            check({tag, " release ready"}, {31'b0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        logic        w;
        logic        uns;
        logic [31:0] wd;
        logic        e;

        for (int i = 0; i < 4096; i++) model[i] = 8'h00;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst req_ready", {31'b0, req_ready}, 32'd0);
        check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst rsp_err", {31'b0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst req_ready", {31'b0, req_ready}, 32'd1);

        // 1. word store/load
        do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0, "t1 st");
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, "t1 ld");

        // 2. byte store, signed/unsigned byte loads, merged word
        do_req(1, 2'b00, 0, 32'h11, 32'h00000080, 32'h0, 0, 2, 0, "t2 st");
        do_req(0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFF80, 0, 2, 0, "t2 lbs");
        do_req(0, 2'b00, 1, 32'h11, 32'h0, 32'h00000080, 0, 2, 0, "t2 lbu");
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0, 2, 0, "t2 lw");

        // 3. crossing word store/load with known neighbours
        do_req(1, 2'b10, 0, 32'h1C, 32'hCAFEF00D, 32'h0, 0, 2, 0, "t3 pre0");
        do_req(1, 2'b10, 0, 32'h20, 32'h0BADC0DE, 32'h0, 0, 2, 0, "t3 pre1");
`ifdef MISALIGN_TRAP_EN
        do_req(1, 2'b10, 0, 32'h1E, 32'h11223344, 32'h0, 1, 2, 0, "t3 st");
        do_req(0, 2'b10, 0, 32'h1E, 32'h0, 32'h0, 1, 2, 0, "t3 ld");
        do_req(0, 2'b10, 0, 32'h1C, 32'h0, 32'hCAFEF00D, 0, 2, 0, "t3 w0");
        do_req(0, 2'b10, 0, 32'h20, 32'h0, 32'h0BADC0DE, 0, 2, 0, "t3 w1");
`else
        do_req(1, 2'b10, 0, 32'h1E, 32'h11223344, 32'h0, 0, 3, 0, "t3 st");
        do_req(0, 2'b10, 0, 32'h1E, 32'h0, 32'h11223344, 0, 3, 0, "t3 ld");
        do_req(0, 2'b10, 0, 32'h1C, 32'h0, 32'h3344F00D, 0, 2, 0, "t3 w0");
        do_req(0, 2'b10, 0, 32'h20, 32'h0, 32'h0BAD1122, 0, 2, 0, "t3 w1");
        do_req(0, 2'b01, 0, 32'h1F, 32'h0, 32'h00002233, 0, 3, 0, "t3 lh x");
`endif

        // 4. range and reserved-size errors
        do_req(0, 2'b01, 0, 32'hFFF, 32'h0, 32'h0, 1, 2, 0, "t4 lh top");
        do_req(0, 2'b10, 0, 32'hFFD, 32'h0, 32'h0, 1, 2, 0, "t4 lw top");
        do_req(1, 2'b10, 0, 32'hFFC, 32'hA5A55A5A, 32'h0, 0, 2, 0, "t4 sw last");
        do_req(0, 2'b10, 0, 32'hFFC, 32'h0, 32'hA5A55A5A, 0, 2, 0, "t4 lw last");
        do_req(1, 2'b10, 0, 32'h00, 32'h01020304, 32'h0, 0, 2, 0, "t4 pre");
        do_req(1, 2'b11, 0, 32'h00, 32'hFFFFFFFF, 32'h0, 1, 2, 0, "t4 rsvd");
        do_req(0, 2'b10, 0, 32'h00, 32'h0, 32'h01020304, 0, 2, 0, "t4 keep");
        do_req(1, 2'b10, 0, 32'h1000, 32'h12345678, 32'h0, 1, 2, 0, "t4 oob");

        // 5. stalled response
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0, 2, 5, "t5");

        // 6. reset during the second half of a crossing store
        do_req(1, 2'b10, 0, 32'h40, 32'hAAAAAAAA, 32'h0, 0, 2, 0, "t6 pre0");
        do_req(1, 2'b10, 0, 32'h44, 32'h55555555, 32'h0, 0, 2, 0, "t6 pre1");
        @(negedge clk);
        check("t6 ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h42;
        req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6 rst valid", {31'b0, rsp_valid}, 32'd0);
        check("t6 rst ready", {31'b0, req_ready}, 32'd0);
        check("t6 rst err", {31'b0, rsp_err}, 32'd0);
        check("t6 rst rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        do_req(0, 2'b10, 0, 32'h40, 32'h0, 32'hAAAAAAAA, 0, 2, 0, "t6 w0");
`else
        model[32'h42] = 8'h78;
        model[32'h43] = 8'h56;
        do_req(0, 2'b10, 0, 32'h40, 32'h0, 32'h5678AAAA, 0, 2, 0, "t6 w0");
`endif
        do_req(0, 2'b10, 0, 32'h44, 32'h0, 32'h55555555, 0, 2, 0, "t6 w1");

        // Model-checked mix over a pre-written window
        for (int i = 0; i < 17; i++) begin
            a = 32'h100 + 32'(4 * i);
            wd = $urandom;
            do_req(1, 2'b10, 0, a, wd, 32'h0, 0, 2, 0, "mix pre");
        end
        for (int i = 0; i < 40; i++) begin
            sz  = 2'($urandom_range(0, 2));
            a   = 32'h100 + 32'($urandom_range(0, 60));
            w   = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            e   = m_err(sz, a);
            do_req(w, sz, uns, a, wd, (w || e) ? 32'h0 : m_load(sz, uns, a), e,
                   m_lat(sz, a), 0, "mix");
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
